sd_spi_byte_engine: RTL and testbench
=====================================

// Module: sd_spi_byte_engine
// PURPOSE
//  SPI mode-0 byte transceiver for the SD-card path; sits directly downstream of CLK_Divider and consumes its CLKout.
//  Runs entirely on the system clock CLKin; treats the divider output (SCLKin) as a registered level, detects its edges, and uses them as shift strobes.
//  Drives SD_SCLK (gated SCLKin), SD_MOSI and SD_CS_n; returns the received byte with a one-cycle Done pulse to the SD controller FSM.
// PARAMETERS
//  DATA_W     8     bits per transfer, MSB first
//  IDLE_MOSI  1'b1  SD_MOSI level when no transfer is active (SD requires high)
// PORTS
//  CLKin     in   1       system clock; all logic on posedge
//  Reset     in   1       synchronous reset, active-low (0 = reset)
//  SCLKin    in   1       CLKout of CLK_Divider (registered in CLKin domain)
//  Start     in   1       request transfer; sampled only in IDLE
//  TxData    in   DATA_W  byte to send; captured on accepted Start
//  CSassert  in   1       1 = select card
//  SD_MISO   in   1       serial data from card
//  SD_SCLK   out  1       SCLKin & sclk_gate
//  SD_MOSI   out  1       serial data to card
//  SD_CS_n   out  1       registered ~CSassert
//  Busy      out  1       1 from accepted Start until Done
//  Done      out  1       one-cycle pulse, RxData valid the same cycle
//  RxData    out  DATA_W  last received byte; held until next Done
// BEHAVIOUR
//  - Reset (Reset==0 on posedge): state=IDLE, Busy=0, Done=0, RxData=0, SD_MOSI=IDLE_MOSI, SD_CS_n=1, sclk_gate=0, bitcnt=0. Reset mid-transfer aborts; no Done.
//  - Edges: sclk_q <= SCLKin; rise = SCLKin & ~sclk_q; fall = ~SCLKin & sclk_q.
//  - FSM IDLE: Start==1 -> latch TxData into tx_sr, Busy<=1, go ALIGN. Start==0 -> stay.
//  - ALIGN: wait for fall; on it, sclk_gate<=1, SD_MOSI<=tx_sr[MSB], bitcnt<=0, go SHIFT. Gate changes only while SCLKin low -> no runt pulse on SD_SCLK.
//  - SHIFT: on rise, rx_sr <= {rx_sr[DATA_W-2:0], SD_MISO}, bitcnt<=bitcnt+1.
//    On fall with bitcnt==DATA_W: sclk_gate<=0, SD_MOSI<=IDLE_MOSI, go DONE.
//    On fall otherwise: tx_sr shifts left, SD_MOSI<=next bit.
//  - DONE (one cycle): RxData<=rx_sr, Done<=1, Busy<=0, go IDLE. Done is 0 in all other cycles.
//  - Latency: Start -> Done = ALIGN wait (<=1 SCLKin period) + DATA_W SCLKin periods + 2 CLKin cycles.
//  - Exactly DATA_W rising edges appear on SD_SCLK per transfer; SD_SCLK is low in IDLE.
//  - Start while Busy is ignored (not queued). Start in the DONE cycle is ignored; Start in the cycle after Done is accepted.
//  - SCLKin rate change (divider switching slow->fast mid-byte) is tolerated: shifting is edge-driven only.
//  - bitcnt is $clog2(DATA_W)+1 bits wide; never wraps within a transfer.
//  - SD_CS_n follows CSassert with 1 CLKin cycle delay, independent of FSM state.
// CONFIGURATION
//  SD_SPI_LOOPBACK_EN defined: rx shift input is SD_MOSI instead of SD_MISO (internal loopback);
//    RxData==TxData after each transfer; SD_MISO is ignored.
//  Undefined: rx shift input is SD_MISO; no loopback logic is synthesised.
// STRUCTURE
//  sd_spi_pkg: state enum {IDLE, ALIGN, SHIFT, DONE} (2-bit encoding), SD_IDLE_MOSI constant, bit-count width function.
//  Sub-module sd_sclk_edge_detect: SCLKin register plus rise/fall outputs; reused by the command/response stage.
//  Top level holds the FSM, the tx/rx shift registers, the gate, and the CS register.
// TESTING
//  1 Reset=0 for 3 cycles mid-SHIFT -> all outputs at reset values, SD_SCLK low, no Done pulse.
//  2 TxData=8'hA5, card model returns 8'h3C -> SD_MOSI bits 1,0,1,0,0,1,0,1 valid at each SD_SCLK rise; RxData=8'h3C; one Done pulse.
//  3 Start held high for 200 cycles -> exactly one transfer per IDLE entry; no Start accepted while Busy=1.
//  4 SCLKin switched from /128 to /4 after bit 3 -> exactly 8 SD_SCLK rises and correct RxData=8'hFF with MISO tied high.
//  5 Compile with SD_SPI_LOOPBACK_EN, TxData=8'h5A -> RxData=8'h5A.
//  6 Back-to-back: Start in the cycle after Done with TxData=8'hFF -> second transfer is accepted, and SD_SCLK shows no glitch between the two bytes.

Source files
------------

// File: rtl/sd_spi_pkg.sv
// sd_spi_pkg -- shared definitions for the SD-card SPI byte path.
//   sd_state_e     : transfer FSM states (2-bit encoding)
//   SD_IDLE_MOSI   : MOSI level between transfers (SD cards require high)
//   sd_bitcnt_w()  : width of a bit counter able to hold the value data_w
package sd_spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } sd_state_e;

    localparam logic SD_IDLE_MOSI = 1'b1;

    // One extra bit so the counter can reach data_w without wrapping.
    function automatic int sd_bitcnt_w(input int data_w);
        return $clog2(data_w) + 1;
    endfunction

endpackage

// File: rtl/sd_spi_byte_engine_if.sv
// sd_spi_byte_engine_if -- host-side handshake between the SD controller FSM
// and the SPI byte engine.
//   Start    : request a transfer (controller -> engine)
//   TxData   : byte to send, captured on accepted Start
//   CSassert : 1 = select card
//   Busy     : transfer in progress (engine -> controller)
//   Done     : one-cycle completion pulse, RxData valid the same cycle
//   RxData   : last received byte
// Modports: master = SD controller side, slave = byte engine side.
interface sd_spi_byte_engine_if #(
    parameter int DATA_W = 8
);
    logic              Start;
    logic [DATA_W-1:0] TxData;
    logic              CSassert;
    logic              Busy;
    logic              Done;
    logic [DATA_W-1:0] RxData;

    modport master (
        output Start, TxData, CSassert,
        input  Busy, Done, RxData
    );

    modport slave (
        input  Start, TxData, CSassert,
        output Busy, Done, RxData
    );
endinterface

// File: rtl/sd_sclk_edge_detect.sv
// sd_sclk_edge_detect -- registers the divider clock level in the system clock
// domain and flags its edges for use as single-cycle shift strobes.
//   clk_i    : system clock
//   rst_n_i  : synchronous reset, active-low
//   sclk_i   : divider output level (already registered in clk_i domain)
//   rise_o   : sclk_i is high this cycle and was low last cycle
//   fall_o   : sclk_i is low this cycle and was high last cycle
module sd_sclk_edge_detect (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic sclk_i,
    output logic rise_o,
    output logic fall_o
);
    logic sclk_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sclk_q <= 1'b0;
        end else begin
            sclk_q <= sclk_i;
        end
    end

    assign rise_o = sclk_i & ~sclk_q;
    assign fall_o = ~sclk_i & sclk_q;
endmodule

// File: rtl/sd_spi_byte_engine.sv
// sd_spi_byte_engine -- SPI mode-0 byte transceiver for the SD-card path.
// Runs on CLKin only; the divider clock SCLKin is treated as a level whose
// edges strobe the shifters, and SD_SCLK is SCLKin gated per transfer.
//   CLKin, Reset   : system clock, synchronous active-low reset
//   SCLKin         : CLK_Divider output
//   SD_MISO        : serial data from card
//   SD_SCLK        : gated SCLKin to card
//   SD_MOSI        : serial data to card, MSB first
//   SD_CS_n        : registered ~CSassert
//   bus (slave)    : Start/TxData/CSassert in, Busy/Done/RxData out
// Build option: define SD_SPI_LOOPBACK_EN to feed SD_MOSI back into the
// receive shifter instead of SD_MISO (internal loopback).
module sd_spi_byte_engine
    import sd_spi_pkg::*;
#(
    parameter int   DATA_W    = 8,
    parameter logic IDLE_MOSI = SD_IDLE_MOSI
) (
    input  logic CLKin,
    input  logic Reset,
    input  logic SCLKin,
    input  logic SD_MISO,
    output logic SD_SCLK,
    output logic SD_MOSI,
    output logic SD_CS_n,
    sd_spi_byte_engine_if.slave bus
);
    localparam int BCW = sd_bitcnt_w(DATA_W);

    logic sclk_rise;
    logic sclk_fall;
    logic rx_in;

    sd_state_e         state_q,  state_d;
    logic [DATA_W-1:0] tx_sr_q,  tx_sr_d;
    logic [DATA_W-1:0] rx_sr_q,  rx_sr_d;
    logic [DATA_W-1:0] rxdata_q, rxdata_d;
    logic [BCW-1:0]    bitcnt_q, bitcnt_d;
    logic              gate_q,   gate_d;
    logic              mosi_q,   mosi_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;
    logic              cs_n_q;

    sd_sclk_edge_detect u_edge (
        .clk_i   (CLKin),
        .rst_n_i (Reset),
        .sclk_i  (SCLKin),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

`ifdef SD_SPI_LOOPBACK_EN
    // mosi_q already holds the bit being presented when the rise arrives.
    logic unused_miso;
    assign unused_miso = SD_MISO;
    assign rx_in       = mosi_q;
`else
    assign rx_in = SD_MISO;
`endif

    always_comb begin
        state_d  = state_q;
        tx_sr_d  = tx_sr_q;
        rx_sr_d  = rx_sr_q;
        rxdata_d = rxdata_q;
        bitcnt_d = bitcnt_q;
        gate_d   = gate_q;
        mosi_d   = mosi_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    tx_sr_d = bus.TxData;
                    busy_d  = 1'b1;
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                // Opening the gate only after a fall keeps the first SD_SCLK
                // high phase full-width.
                if (sclk_fall) begin
                    gate_d   = 1'b1;
                    mosi_d   = tx_sr_q[DATA_W-1];
                    bitcnt_d = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (sclk_rise) begin
                    rx_sr_d  = {rx_sr_q[DATA_W-2:0], rx_in};
                    bitcnt_d = bitcnt_q + 1'b1;
                end else if (sclk_fall) begin
                    if (bitcnt_q == BCW'(DATA_W)) begin
                        // Completion outputs are registered on entry so that
                        // Done, RxData and Busy=0 coincide with the DONE cycle.
                        gate_d   = 1'b0;
                        mosi_d   = IDLE_MOSI;
                        rxdata_d = rx_sr_q;
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                        state_d  = DONE;
                    end else begin
                        tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
                        mosi_d  = tx_sr_q[DATA_W-2];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLKin) begin
        if (!Reset) begin
            state_q  <= IDLE;
            tx_sr_q  <= '0;
            rx_sr_q  <= '0;
            rxdata_q <= '0;
            bitcnt_q <= '0;
            gate_q   <= 1'b0;
            mosi_q   <= IDLE_MOSI;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cs_n_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            tx_sr_q  <= tx_sr_d;
            rx_sr_q  <= rx_sr_d;
            rxdata_q <= rxdata_d;
            bitcnt_q <= bitcnt_d;
            gate_q   <= gate_d;
            mosi_q   <= mosi_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cs_n_q   <= ~bus.CSassert;
        end
    end

    assign SD_SCLK    = SCLKin & gate_q;
    assign SD_MOSI    = mosi_q;
    assign SD_CS_n    = cs_n_q;
    assign bus.Busy   = busy_q;
    assign bus.Done   = done_q;
    assign bus.RxData = rxdata_q;
endmodule

// File: tb/tb_sd_spi_byte_engine.sv
module tb_sd_spi_byte_engine;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sclk  = 1'b0;
    logic miso;
    logic sd_sclk, sd_mosi, sd_cs_n;

    sd_spi_byte_engine_if #(.DATA_W(8)) bus ();

    sd_spi_byte_engine #(.DATA_W(8), .IDLE_MOSI(1'b1)) dut (
        .CLKin   (clk),
        .Reset   (rst_n),
        .SCLKin  (sclk),
        .SD_MISO (miso),
        .SD_SCLK (sd_sclk),
        .SD_MOSI (sd_mosi),
        .SD_CS_n (sd_cs_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Clock divider model: SCLKin toggles every 'half' system clocks.
    int half = 2;
    int hcnt = 0;
    always @(posedge clk) begin
        if (hcnt >= half - 1) begin
            hcnt <= 0;
            sclk <= ~sclk;
        end else begin
            hcnt <= hcnt + 1;
        end
    end

    // Card model (SPI mode 0): presents bit 7 first, advances on each SD_SCLK
    // fall, and captures MOSI on each SD_SCLK rise.
    logic [7:0] card_resp = 8'h00;
    logic [2:0] card_idx  = 3'd0;
    always @(negedge sd_sclk or negedge rst_n) begin
        if (!rst_n) card_idx <= 3'd0;
        else        card_idx <= card_idx + 3'd1;
    end
    assign miso = card_resp[~card_idx];

    int         rise_total = 0;
    logic [7:0] mosi_cap   = 8'h00;
    always @(posedge sd_sclk) begin
        rise_total <= rise_total + 1;
        mosi_cap   <= {mosi_cap[6:0], sd_mosi};
    end

    // Reference model: a transfer is accepted whenever Start is high while the
    // engine is idle; each accepted transfer must end with one Done carrying
    // the card byte (or the sent byte in loopback), the sent byte seen on MOSI
    // at eight SD_SCLK rises.
    typedef struct packed {
        logic [7:0] rx;
        logic [7:0] tx;
    } exp_t;
    exp_t       sb[$];
    logic       m_idle   = 1'b1;
    logic [7:0] last_rx  = 8'h00;
    logic       cs_exp   = 1'b1;
    int         rise_base = 0;
    int         n_accept  = 0;

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                m_idle    = 1'b1;
                last_rx   = 8'h00;
                cs_exp    = 1'b1;
                rise_base = rise_total;
            end else begin
                if (bus.Done) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 32'(bus.Done), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("rxdata", 32'(bus.RxData), 32'(e.rx));
                        chk("mosi_bits", 32'(mosi_cap), 32'(e.tx));
                        chk("sclk_rises", 32'(rise_total - rise_base), 32'd8);
                        last_rx = e.rx;
                    end
                    rise_base = rise_total;
                    chk("busy_at_done", 32'(bus.Busy), 32'd0);
                end else begin
                    chk("busy", 32'(bus.Busy), 32'(!m_idle));
                    chk("rxdata_hold", 32'(bus.RxData), 32'(last_rx));
                    if (m_idle) begin
                        chk("sclk_idle", 32'(sd_sclk), 32'd0);
                        chk("mosi_idle", 32'(sd_mosi), 32'd1);
                    end
                end
                chk("cs_n", 32'(sd_cs_n), 32'(cs_exp));
                cs_exp = ~bus.CSassert;
                if (m_idle && bus.Start) begin
`ifdef SD_SPI_LOOPBACK_EN
                    e.rx = bus.TxData;
`else
                    e.rx = card_resp;
`endif
                    e.tx = bus.TxData;
                    sb.push_back(e);
                    m_idle = 1'b0;
                    n_accept++;
                end
                if (bus.Done) m_idle = 1'b1;
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(m_idle && sb.size() == 0) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= budget) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_idle: transfer still pending after %0d cycles", budget);
        end
    endtask

    task automatic issue(input logic [7:0] tx, input logic [7:0] resp);
        card_resp  = resp;
        bus.TxData = tx;
        bus.Start  = 1'b1;
        @(posedge clk); #1;
        bus.Start  = 1'b0;
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int r0;
        int n;
        int acc0;
        bus.Start    = 1'b0;
        bus.TxData   = 8'h00;
        bus.CSassert = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(bus.Busy), 32'd0);
        chk("rst_done", 32'(bus.Done), 32'd0);
        chk("rst_rxdata", 32'(bus.RxData), 32'd0);
        chk("rst_cs_n", 32'(sd_cs_n), 32'd1);
        chk("rst_mosi", 32'(sd_mosi), 32'd1);
        chk("rst_sclk", 32'(sd_sclk), 32'd0);
        @(posedge clk); #1;

        // Basic byte A5 out, 3C in
        half = 2;
        bus.CSassert = 1'b1;
        issue(8'hA5, 8'h3C);
        wait_idle(500);

        // Reset three cycles in the middle of a shift: aborts, no Done
        half = 4;
        issue(8'h96, 8'h69);
        repeat (40) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(bus.Busy), 32'd0);
        chk("abort_done", 32'(bus.Done), 32'd0);
        chk("abort_rxdata", 32'(bus.RxData), 32'd0);
        chk("abort_cs_n", 32'(sd_cs_n), 32'd1);
        chk("abort_sclk", 32'(sd_sclk), 32'd0);
        chk("abort_mosi", 32'(sd_mosi), 32'd1);
        repeat (150) @(posedge clk);
        #1;

        // Divider switches from /128 to /4 after the third bit, MISO high
        half = 64;
        r0 = rise_total;
        issue(8'hC3, 8'hFF);
        n = 0;
        while ((rise_total - r0) < 3 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 3000) chk("rate_switch_reach_bit3", 32'(rise_total - r0), 32'd3);
        half = 2;
        wait_idle(3000);

        // 5A transfer (loopback build returns 5A)
        issue(8'h5A, 8'h3C);
        wait_idle(500);

        // Randomized transfers with stray Starts injected while busy
        for (int i = 0; i < 16; i++) begin
            half = int'($urandom_range(2, 6));
            bus.CSassert = 1'($urandom_range(0, 1));
            issue(8'($urandom), 8'($urandom));
            repeat ($urandom_range(3, 30)) @(posedge clk);
            #1;
            bus.TxData = 8'($urandom);
            bus.Start  = 1'b1;
            @(posedge clk); #1;
            bus.Start  = 1'b0;
            wait_idle(1000);
        end

        // Start held high: back-to-back FF transfers, one per IDLE entry
        half = 2;
        bus.CSassert = 1'b1;
        card_resp  = 8'h81;
        bus.TxData = 8'hFF;
        acc0 = n_accept;
        bus.Start = 1'b1;
        repeat (200) @(posedge clk);
        #1 bus.Start = 1'b0;
        wait_idle(500);
        chk("held_start_multiple", 32'(n_accept - acc0 >= 2), 32'd1);

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
